// File: rtl/puzzle_dealer.sv
// Deals one solvable 24-game number set per request, picking the index from an LFSR,
// a sequential pointer or a direct select, and skipping indices dealt recently.
module puzzle_dealer #(
  parameter int unsigned NUM_W      = 10,
  parameter int unsigned HIST_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [1:0]       i_mode,
  input  logic [3:0]       i_sel_idx,
  input  logic             i_clear_hist,
  output logic             o_busy,
  output logic             o_valid,
  output logic [3:0]       o_index,
  output logic [NUM_W-1:0] o_num1,
  output logic [NUM_W-1:0] o_num2,
  output logic [NUM_W-1:0] o_num3,
  output logic [NUM_W-1:0] o_num4,
  output logic [7:0]       o_deal_count
);

  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {StIdle, StCheck} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [15:0]           r_lfsr;
  logic [15:0]           w_lfsr_next;
  logic [3:0]            r_cand;
  logic [3:0]            r_retries;
  logic [3:0]            r_seq_ptr;
  logic [3:0]            r_hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] r_hist_vld;
  logic                  r_valid;
  logic [3:0]            r_index;
  logic [NUM_W-1:0]      r_num1;
  logic [NUM_W-1:0]      r_num2;
  logic [NUM_W-1:0]      r_num3;
  logic [NUM_W-1:0]      r_num4;
  logic [7:0]            r_count;
  logic                  w_hit;
  logic                  w_collide;
  logic                  w_accept;
  logic                  w_step;
  logic                  w_deal;
  logic [15:0]           w_rom;

  function automatic logic [15:0] rom_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = 16'h248B;
      4'd1:    e = 16'h26CD;
      4'd2:    e = 16'h357D;
      4'd3:    e = 16'h366B;
      4'd4:    e = 16'h137C;
      4'd5:    e = 16'h789A;
      4'd6:    e = 16'h26BC;
      4'd7:    e = 16'h348D;
      4'd8:    e = 16'h36AA;
      4'd9:    e = 16'h449C;
      4'd10:   e = 16'h4679;
      4'd11:   e = 16'h56BD;
      4'd12:   e = 16'h88BC;
      4'd13:   e = 16'hBCCD;
      4'd14:   e = 16'h1234;
      default: e = 16'h78AD;
    endcase
    return e;
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_rom       = rom_entry(r_cand);

  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
      if (r_hist_vld[i] && (r_hist[i] == r_cand)) w_hit = 1'b1;
    end
  end

  // Retry cap is only a safety bound; a free index always exists within HIST_DEPTH steps.
  assign w_collide = w_hit && ({28'd0, r_retries} < HIST_DEPTH);

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_step    = 1'b0;
    w_deal    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_req) begin
          w_accept  = 1'b1;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        if (w_collide) begin
          w_step = 1'b1;
        end else begin
          w_deal    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr     <= SeedEff;
      r_cand     <= 4'd0;
      r_retries  <= 4'd0;
      r_seq_ptr  <= 4'd0;
      r_hist_vld <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 4'd0;
      r_valid    <= 1'b0;
      r_index    <= 4'd0;
      r_num1     <= '0;
      r_num2     <= '0;
      r_num3     <= '0;
      r_num4     <= '0;
      r_count    <= 8'd0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_valid <= w_deal;
      if (w_accept) begin
        case (i_mode)
          2'd0:    r_cand <= r_lfsr[3:0];
          2'd2:    r_cand <= i_sel_idx;
          default: r_cand <= r_seq_ptr;
        endcase
        r_retries <= 4'd0;
      end else if (w_step) begin
        r_cand    <= r_cand + 4'd1;
        r_retries <= r_retries + 4'd1;
      end
      if ((r_state == StIdle) && i_clear_hist) r_hist_vld <= '0;
      if (w_deal) begin
        r_index   <= r_cand;
        r_num1    <= NUM_W'(w_rom[15:12]);
        r_num2    <= NUM_W'(w_rom[11:8]);
        r_num3    <= NUM_W'(w_rom[7:4]);
        r_num4    <= NUM_W'(w_rom[3:0]);
        r_count   <= r_count + 8'd1;
        r_seq_ptr <= r_cand + 4'd1;
        r_hist[0]     <= r_cand;
        r_hist_vld[0] <= 1'b1;
        for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
          r_hist[i]     <= r_hist[i-1];
          r_hist_vld[i] <= r_hist_vld[i-1];
        end
      end
    end
  end

  assign o_busy       = (r_state == StCheck);
  assign o_valid      = r_valid;
  assign o_index      = r_index;
  assign o_num1       = r_num1;
  assign o_num2       = r_num2;
  assign o_num3       = r_num3;
  assign o_num4       = r_num4;
  assign o_deal_count = r_count;

endmodule

// File: doc/puzzle_dealer.md
# puzzle_dealer

- Clocked successor to the fixed 16-set lookup: on request, deals one guaranteed-solvable four-number set for the 24 game.
- Index source is selectable: pseudo-random LFSR, sequential, or direct.
- A history window prevents the same set from being dealt again within the last HIST_DEPTH deals.
- Sits between the game controller (request/valid) and the display/arithmetic path (num1..num4).

## Interface
- NUM_W, 10, width of each number output; values zero-extended, legal range 4..16.
- HIST_DEPTH, 4, number of recent indices blocked from re-dealing; legal range 1..8.
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
- Ports, with the clock and reset fixed as: clk, input, 1, single clock; rst, input, 1, synchronous active-high reset.
- req, input, 1: deal request, sampled on the rising edge while idle.
- mode, input, 2: source select, sampled with req. 0 = random, 1 = sequential, 2 = direct, 3 = sequential.
- sel_idx, input, 4: requested index in direct mode.
- clear_hist, input, 1: invalidates all history entries; honoured only while idle.
- busy, output, 1: high from the accepted req until the deal completes.
- valid, output, 1: one-cycle pulse marking a new deal on num1..num4/index.
- index, output, 4: table index of the dealt set.
- num1, num2, num3, num4, output, NUM_W each: dealt numbers, held until the next deal.
- deal_count, output, 8: number of completed deals; wraps 255 -> 0.

## Operation
- The ROM has 16 entries, 4 bits each, zero-extended. Each entry lists num1..num4:
  - 0: 2,4,8,11
  - 1: 2,6,12,13
  - 2: 3,5,7,13
  - 3: 3,6,6,11
  - 4: 1,3,7,12
  - 5: 7,8,9,10
  - 6: 2,6,11,12
  - 7: 3,4,8,13
  - 8: 3,6,10,10
  - 9: 4,4,9,12
  - 10: 4,6,7,9
  - 11: 5,6,11,13
  - 12: 8,8,11,12
  - 13: 11,12,12,13
  - 14: 1,2,3,4
  - 15: 7,8,10,13
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every non-reset cycle, including while idle and busy.
- The FSM has two states, IDLE and CHECK.
- IDLE, req=1: cand <= lfsr[3:0] (mode 0), seq_ptr (modes 1/3), or sel_idx (mode 2). Then retries <= 0, busy <= 1, go to CHECK. While idle, valid is 0.
- CHECK, collision: cand equals any valid history entry and retries < HIST_DEPTH. Then cand <= cand+1 (15 wraps to 0), retries++, stay in CHECK.
- CHECK, otherwise:
  - index <= cand; num1..num4 <= ROM[cand]; valid <= 1 for one cycle.
  - History shifts in cand (oldest dropped); deal_count++.
  - seq_ptr <= cand+1 (mod 16); busy <= 0; go to IDLE.
- A free index is guaranteed: the history holds at most 8 of 16 indices, so among HIST_DEPTH+1 consecutive candidates at least one is free. The retry cap is a safety bound only.
- req while busy is ignored; it is not queued.
- clear_hist together with req in IDLE: the clear applies first, so the request checks against an empty history.
- clear_hist while busy is ignored.

## Timing
- Reset values:
  - state IDLE; busy 0; valid 0; index 0.
  - num1..num4 0; deal_count 0; seq_ptr 0.
  - all history entries invalid; lfsr LFSR_SEED.
- rst mid-deal aborts: no valid pulse, no history or count update.
- Latency: req sampled at edge E0 puts the FSM in CHECK after E0. With no collision, outputs update and valid is high for the cycle after E1. Each collision adds exactly one cycle; the worst case is E1+HIST_DEPTH.
- busy is high after E0 and low in the same cycle valid is high, so a new req can be sampled on the edge that ends the valid cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then mode=1, req pulses ×3 -> deals index 0 (2,4,8,11), index 1 (2,6,12,13), index 2 (3,5,7,13). Each valid appears one cycle after the sampled req; deal_count = 3.
- Direct mode, sel_idx=5 dealt, then sel_idx=5 again -> second deal is index 6 (2,6,11,12) with one extra cycle of latency. Requesting 5, 6, 7 with 5 and 6 in history -> index 7 after 2 extra cycles.
- With HIST_DEPTH=4: deal 0,1,2,3 directly, then sel_idx=0 -> index 4 (1,3,7,12) after 4 retries.
- Assert clear_hist and direct sel_idx=5 together in IDLE after 5 was dealt -> index 5 returned with minimum latency.
- Mode 0, LFSR_SEED=0, 1000 deals -> no lock-up. Each dealt index matches a reference model of lfsr[3:0] plus collision stepping. No index repeats within any window of HIST_DEPTH+1 deals.
- Assert rst while in CHECK -> no valid pulse, all outputs at reset values. req during busy -> ignored, deal_count increments once.
